// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage; drives the dmem req/gnt/rvalid port, aligns stores, extends loads.
// Optional feature macro: NPC_LSU_MISALIGN_EN (trap naturally misaligned accesses instead of issuing them).
module mem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        reg_wen_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [63:0] alu_res_i,
  input  logic [63:0] store_data_i,
  input  logic [7:0]  wmask_i,
  input  logic        s_flag_i,
  input  logic [2:0]  rd_buf_flag_i,
  input  logic [3:0]  expand_signed_i,
  input  logic        ebreak_flag_i,
  input  logic [63:0] pc_i,
  output logic        mem_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wmask_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_wen_o,
  output logic [4:0]  wb_waddr_o,
  output logic [63:0] wb_wdata_o,
  output logic [63:0] wb_pc_o,
  output logic        wb_ebreak_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state;
  logic [63:0] addr_q, pc_q, sh_data, ld_data;
  logic [2:0]  sz_q;
  logic [4:0]  rd_q;
  logic        sg_q, wen_q, eb_q, ld_sz, mem_op, mis;
  assign ld_sz  = rd_buf_flag_i != 3'd0 && rd_buf_flag_i <= 3'd4;
  assign mem_op = valid_i & (s_flag_i | ld_sz);
`ifdef NPC_LSU_MISALIGN_EN
  logic [2:0] a, esz;
  assign a   = alu_res_i[2:0];
  // stores carry no size field, so infer it from the lane-0 byte mask
  assign esz = s_flag_i ? (wmask_i == 8'hFF ? 3'd4 : wmask_i == 8'h0F ? 3'd3 : wmask_i == 8'h03 ? 3'd2 : 3'd1) : rd_buf_flag_i;
  assign mis = mem_op & ((esz == 3'd2 & a[0]) | (esz == 3'd3 & |a[1:0]) | (esz == 3'd4 & |a));
`else
  assign mis = 1'b0;
`endif
  assign dmem_addr_o = {addr_q[63:3], 3'b000};
  assign mem_stall_o = state == IDLE ? mem_op & ~mis :
                       state == REQ  ? ~(dmem_we_o & dmem_gnt_i) :
                       state == WAIT ? ~dmem_rvalid_i : 1'b0;
  // bytes shifted in from above byte 7 are zero, which is the defined result for overhanging loads
  assign sh_data = dmem_rdata_i >> {addr_q[2:0], 3'b000};
  assign ld_data = sz_q == 3'd1 ? {{56{sg_q & sh_data[7]}},  sh_data[7:0]}  :
                   sz_q == 3'd2 ? {{48{sg_q & sh_data[15]}}, sh_data[15:0]} :
                   sz_q == 3'd3 ? {{32{sg_q & sh_data[31]}}, sh_data[31:0]} : sh_data;
  // transaction FSM with registered dmem request fields and writeback record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      pc_q         <= '0;
      sz_q         <= '0;
      rd_q         <= '0;
      sg_q         <= 1'b0;
      wen_q        <= 1'b0;
      eb_q         <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_wdata_o <= '0;
      dmem_wmask_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_wen_o     <= 1'b0;
      wb_waddr_o   <= '0;
      wb_wdata_o   <= '0;
      wb_pc_o      <= 64'h8000_0000;
      wb_ebreak_o  <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      if (state == IDLE && valid_i) begin
        wb_waddr_o  <= reg_waddr_i;
        wb_pc_o     <= pc_i;
        wb_ebreak_o <= ebreak_flag_i;
        if (mis) begin
          wb_valid_o <= 1'b1;
          wb_wen_o   <= 1'b0;
          misalign_o <= 1'b1;
        end else if (mem_op) begin
          state        <= REQ;
          addr_q       <= alu_res_i;
          pc_q         <= pc_i;
          sz_q         <= rd_buf_flag_i;
          rd_q         <= reg_waddr_i;
          sg_q         <= |expand_signed_i;
          wen_q        <= reg_wen_i;
          eb_q         <= ebreak_flag_i;
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= s_flag_i;
          dmem_wdata_o <= store_data_i << {alu_res_i[2:0], 3'b000};
          dmem_wmask_o <= wmask_i << alu_res_i[2:0];
        end else begin
          wb_valid_o <= 1'b1;
          wb_wen_o   <= reg_wen_i & |reg_waddr_i;
          wb_wdata_o <= alu_res_i;
        end
      end else if (state == REQ && dmem_gnt_i) begin
        dmem_req_o <= 1'b0;
        state      <= dmem_we_o ? IDLE : WAIT;
        if (dmem_we_o) begin
          wb_valid_o  <= 1'b1;
          wb_wen_o    <= 1'b0;
          wb_waddr_o  <= rd_q;
          wb_wdata_o  <= '0;
          wb_pc_o     <= pc_q;
          wb_ebreak_o <= eb_q;
        end
      end else if (state == WAIT && dmem_rvalid_i) begin
        state       <= IDLE;
        wb_valid_o  <= 1'b1;
        wb_wen_o    <= wen_q & |rd_q;
        wb_waddr_o  <= rd_q;
        wb_wdata_o  <= ld_data;
        wb_pc_o     <= pc_q;
        wb_ebreak_o <= eb_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed table-driven bench for mem_lsu (build with +define+NPC_LSU_MISALIGN_EN for the trap variant).
module tb_mem_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid_i = 0, reg_wen_i = 0, s_flag_i = 0, ebreak_flag_i = 0;
  logic [4:0]  reg_waddr_i = 0;
  logic [63:0] alu_res_i = 0, store_data_i = 0, pc_i = 0, dmem_rdata_i = 0;
  logic [7:0]  wmask_i = 0;
  logic [2:0]  rd_buf_flag_i = 0;
  logic [3:0]  expand_signed_i = 0;
  logic        dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic        mem_stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_wen_o, wb_ebreak_o, misalign_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, wb_wdata_o, wb_pc_o;
  logic [7:0]  dmem_wmask_o;
  logic [4:0]  wb_waddr_o;
  int checks = 0, errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic        st;
    logic [2:0]  sz;
    logic        sg;
    logic [4:0]  rd;
    logic [63:0] sdata;
    logic [7:0]  wm;
    logic [63:0] rdata;
    logic [63:0] exp;
    logic [7:0]  exp_wm;
    logic        exp_wen;
  } vec_t;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .reg_wen_i(reg_wen_i), .reg_waddr_i(reg_waddr_i),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i), .wmask_i(wmask_i), .s_flag_i(s_flag_i),
    .rd_buf_flag_i(rd_buf_flag_i), .expand_signed_i(expand_signed_i), .ebreak_flag_i(ebreak_flag_i),
    .pc_i(pc_i), .mem_stall_o(mem_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_wen_o(wb_wen_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .wb_pc_o(wb_pc_o), .wb_ebreak_o(wb_ebreak_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    valid_i = 1; s_flag_i = t.st; rd_buf_flag_i = t.sz; expand_signed_i = {3'b0, t.sg};
    reg_wen_i = 1; reg_waddr_i = t.rd; alu_res_i = t.addr; store_data_i = t.sdata;
    wmask_i = t.wm; pc_i = t.addr; ebreak_flag_i = 0;
  endtask

  task automatic idle_in();
    valid_i = 0; s_flag_i = 0; rd_buf_flag_i = 0; expand_signed_i = 0;
  endtask

  task automatic run_vec(input vec_t t);
    drive(t);
    #1 chk("stall_idle", mem_stall_o, 1);
    step();
    idle_in();
    #1 chk("req", dmem_req_o, 1);
    chk("addr", dmem_addr_o, {t.addr[63:3], 3'b000});
    chk("we", dmem_we_o, t.st);
    if (t.st) begin
      chk("wdata", dmem_wdata_o, t.exp);
      chk("wmask", dmem_wmask_o, t.exp_wm);
    end
    dmem_gnt_i = 1;
    #1 chk("stall_req", mem_stall_o, !t.st);
    step();
    dmem_gnt_i = 0;
    if (!t.st) begin
      chk("req_wait", dmem_req_o, 0);
      chk("wbv_wait", wb_valid_o, 0);
      dmem_rvalid_i = 1; dmem_rdata_i = t.rdata;
      #1 chk("stall_wait", mem_stall_o, 0);
      step();
      dmem_rvalid_i = 0;
      chk("ld_wdata", wb_wdata_o, t.exp);
      chk("ld_waddr", wb_waddr_o, t.rd);
    end
    chk("wbv_done", wb_valid_o, 1);
    chk("wb_wen", wb_wen_o, t.exp_wen);
    chk("wb_pc", wb_pc_o, t.addr);
    step();
    chk("wbv_pulse", wb_valid_o, 0);
  endtask

  initial begin
    vec_t v[10];
    vec_t m;
    int pulses;
    v[0] = '{64'h8000_1004, 0, 3, 1, 5,  0, 0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1};
    v[1] = '{64'h8000_0003, 0, 1, 0, 6,  0, 0, 64'h0000_0000_F100_0000, 64'h0000_0000_0000_00F1, 0, 1};
    v[2] = '{64'h8000_0003, 0, 1, 1, 6,  0, 0, 64'h0000_0000_F100_0000, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1};
    v[3] = '{64'h8000_0006, 1, 0, 0, 0,  64'hABCD, 8'h03, 0, 64'hABCD_0000_0000_0000, 8'hC0, 0};
    v[4] = '{64'h8000_0008, 0, 4, 0, 7,  0, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 1};
    v[5] = '{64'h8000_0012, 0, 2, 1, 8,  0, 0, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765, 0, 1};
    v[6] = '{64'h8000_0020, 0, 3, 0, 0,  0, 0, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678, 0, 0};
    v[7] = '{64'h8000_0030, 1, 0, 0, 0,  64'h1122_3344_5566_7788, 8'hFF, 0, 64'h1122_3344_5566_7788, 8'hFF, 0};
    v[8] = '{64'h8000_0007, 1, 0, 0, 0,  64'h5A, 8'h01, 0, 64'h5A00_0000_0000_0000, 8'h80, 0};
    v[9] = '{64'h8000_0040, 1, 3, 0, 4,  64'h99, 8'h0F, 0, 64'h0000_0000_0000_0099, 8'h0F, 0};

    step(); step();
    chk("rst_pc", wb_pc_o, 64'h8000_0000);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_mis", misalign_o, 0);
    rst_n = 1;
    step();

    // non-memory op: one-cycle writeback, no stall
    valid_i = 1; reg_wen_i = 1; reg_waddr_i = 3; alu_res_i = 64'hDEAD; pc_i = 64'h100; ebreak_flag_i = 1;
    #1 chk("alu_stall", mem_stall_o, 0);
    step();
    valid_i = 0; ebreak_flag_i = 0;
    chk("alu_wbv", wb_valid_o, 1);
    chk("alu_wdata", wb_wdata_o, 64'hDEAD);
    chk("alu_wen", wb_wen_o, 1);
    chk("alu_waddr", wb_waddr_o, 3);
    chk("alu_pc", wb_pc_o, 64'h100);
    chk("alu_ebreak", wb_ebreak_o, 1);
    chk("alu_req", dmem_req_o, 0);
    step();
    chk("alu_pulse", wb_valid_o, 0);

    for (int i = 0; i < 10; i++) run_vec(v[i]);

    // store with grant withheld for 4 cycles
    m = '{64'h8000_0018, 1, 0, 0, 2, 64'h77, 8'h01, 0, 64'h77, 8'h01, 0};
    drive(m);
    step();
    idle_in();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_req", dmem_req_o, 1);
      chk("hold_stall", mem_stall_o, 1);
      chk("hold_addr", dmem_addr_o, 64'h8000_0018);
      chk("hold_wdata", dmem_wdata_o, 64'h77);
      chk("hold_wmask", dmem_wmask_o, 8'h01);
      pulses += wb_valid_o;
      step();
    end
    dmem_gnt_i = 1;
    #1 chk("hold_stall_gnt", mem_stall_o, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      pulses += wb_valid_o;
      step();
    end
    dmem_gnt_i = 0;
    chk("hold_pulses", pulses, 1);
    chk("stray_gnt_req", dmem_req_o, 0);

    // reset while waiting for read data, then a stray rvalid
    drive(v[0]);
    step();
    idle_in();
    dmem_gnt_i = 1;
    step();
    dmem_gnt_i = 0;
    #2 rst_n = 0;
    #1 chk("arst_req", dmem_req_o, 0);
    chk("arst_pc", wb_pc_o, 64'h8000_0000);
    chk("arst_stall", mem_stall_o, 0);
    step();
    rst_n = 1;
    dmem_rvalid_i = 1; dmem_rdata_i = 64'hFFFF_FFFF_8000_0000;
    step();
    dmem_rvalid_i = 0;
    chk("arst_wbv", wb_valid_o, 0);
    chk("arst_wdata", wb_wdata_o, 0);
    run_vec(v[1]);

    // word load at a misaligned address
`ifdef NPC_LSU_MISALIGN_EN
    m = '{64'h8000_0002, 0, 3, 0, 9, 0, 0, 0, 0, 0, 0};
    drive(m);
    #1 chk("mis_stall", mem_stall_o, 0);
    step();
    idle_in();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_wbv", wb_valid_o, 1);
    chk("mis_wen", wb_wen_o, 0);
    chk("mis_req", dmem_req_o, 0);
    step();
    chk("mis_end", misalign_o, 0);
    chk("mis_req2", dmem_req_o, 0);
`else
    m = '{64'h8000_0002, 0, 3, 0, 9, 0, 0, 64'hAABB_CCDD_EEFF_0000, 64'h0000_0000_CCDD_EEFF, 0, 1};
    run_vec(m);
    chk("mis_tied", misalign_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
